// File: rtl/tile_map_engine.sv
// Tile-map fetch engine: turns the raster position into a tile index and fine
// pixel offsets. It holds a writable tile map, applies a per-frame scroll with
// wrap-around, and sweeps the whole map to FILL on reset or on request.
module tile_map_engine #(
    parameter int unsigned H_LEFT        = 144,
    parameter int unsigned V_TOP         = 31,
    parameter int unsigned TILE_SHIFT    = 3,
    parameter int unsigned COL_BITS      = 7,
    parameter int unsigned ROW_BITS      = 6,
    parameter int unsigned IDX_W         = 4,
    parameter int unsigned FILL          = 0,
    parameter bit          WR_BLANK_ONLY = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [9:0]                     hcount,
    input  logic [9:0]                     vcount,
    input  logic                           bright,
    input  logic [COL_BITS+TILE_SHIFT-1:0] scroll_x,
    input  logic [ROW_BITS+TILE_SHIFT-1:0] scroll_y,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [COL_BITS-1:0]            wr_col,
    input  logic [ROW_BITS-1:0]            wr_row,
    input  logic [IDX_W-1:0]               wr_data,
    input  logic                           clr_req,
    output logic                           clr_busy,
    output logic [IDX_W-1:0]               tselect,
    output logic [TILE_SHIFT-1:0]          fine_x,
    output logic [TILE_SHIFT-1:0]          fine_y,
    output logic                           tvalid
);

    localparam int unsigned PXW   = COL_BITS + TILE_SHIFT;
    localparam int unsigned PYW   = ROW_BITS + TILE_SHIFT;
    localparam int unsigned AW    = COL_BITS + ROW_BITS;
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic {StClear, StIdle} state_t;

    logic [IDX_W-1:0]      mem [DEPTH];
    state_t                state_q;
    logic [AW-1:0]         clr_cnt_q;
    logic                  clr_busy_q;
    logic [PXW-1:0]        sx_q;
    logic [PYW-1:0]        sy_q;
    logic [AW-1:0]         addr0_q;
    logic [TILE_SHIFT-1:0] fx0_q, fy0_q, fx1_q, fy1_q;
    logic                  v0_q, v1_q;
    logic [IDX_W-1:0]      rdata_q;

    logic [PXW-1:0]        xpos, px;
    logic [PYW-1:0]        ypos, py;
    logic                  we;
    logic [AW-1:0]         waddr;
    logic [IDX_W-1:0]      wdata;

    assign clr_busy = clr_busy_q;

    // Write arbitration: the sweep owns the port while clearing; clr_req blocks host writes.
    always_comb begin
        wr_ready = (state_q == StIdle) && !rst && !clr_req && (WR_BLANK_ONLY ? !bright : 1'b1);
        we       = 1'b0;
        waddr    = {wr_row, wr_col};
        wdata    = wr_data;
        if (!rst) begin
            if (state_q == StClear) begin
                we    = 1'b1;
                waddr = clr_cnt_q;
                wdata = IDX_W'(FILL);
            end else if (wr_valid && wr_ready) begin
                we = 1'b1;
            end
        end
    end

    // Clear-sweep FSM; clr_busy is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StClear;
            clr_cnt_q  <= '0;
            clr_busy_q <= 1'b1;
        end else begin
            unique case (state_q)
                StClear: begin
                    if (clr_req) begin
                        clr_cnt_q <= '0;
                    end else if (clr_cnt_q == AW'(DEPTH - 1)) begin
                        state_q    <= StIdle;
                        clr_cnt_q  <= '0;
                        clr_busy_q <= 1'b0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                StIdle: begin
                    if (clr_req) begin
                        state_q    <= StClear;
                        clr_cnt_q  <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= StClear;
                    clr_cnt_q  <= '0;
                    clr_busy_q <= 1'b1;
                end
            endcase
        end
    end

    // Scroll shadow registers, latched once per frame at the raster origin.
    always_ff @(posedge clk) begin
        if (rst) begin
            sx_q <= '0;
            sy_q <= '0;
        end else if (hcount == 10'd0 && vcount == 10'd0) begin
            sx_q <= scroll_x;
            sy_q <= scroll_y;
        end
    end

    // Scrolled pixel position; wrap-around is plain truncation to PXW/PYW bits.
    always_comb begin
        xpos = bright ? PXW'(hcount) - PXW'(H_LEFT + 1) : '0;
        ypos = bright ? PYW'(vcount) - PYW'(V_TOP + 1) : '0;
        px   = xpos + sx_q;
        py   = ypos + sy_q;
    end

    // Stage 0: map address and fine offsets.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr0_q <= '0;
            fx0_q   <= '0;
            fy0_q   <= '0;
            v0_q    <= 1'b0;
        end else begin
            addr0_q <= {py[PYW-1:TILE_SHIFT], px[PXW-1:TILE_SHIFT]};
            fx0_q   <= px[TILE_SHIFT-1:0];
            fy0_q   <= py[TILE_SHIFT-1:0];
            v0_q    <= bright;
        end
    end

    // Map RAM write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Stage 1: display read (read-first against a same-cycle write) plus delay-matching.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            fx1_q   <= '0;
            fy1_q   <= '0;
            v1_q    <= 1'b0;
        end else begin
            rdata_q <= mem[addr0_q];
            fx1_q   <= fx0_q;
            fy1_q   <= fy0_q;
            v1_q    <= v0_q;
        end
    end

    // Output stage: blank pixels present all-zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            tselect <= '0;
            fine_x  <= '0;
            fine_y  <= '0;
            tvalid  <= 1'b0;
        end else begin
            tselect <= v1_q ? rdata_q : '0;
            fine_x  <= v1_q ? fx1_q : '0;
            fine_y  <= v1_q ? fy1_q : '0;
            tvalid  <= v1_q;
        end
    end

endmodule
